sram_arbiter: RTL and testbench

Two-port byte-wide arbiter sharing the single 16-bit asynchronous board SRAM between the CPU (PRG side) and the PPU (CHR/nametable side). It sits between the mapper address outputs and the top-level `sram_*` pins. It serialises requests, sequences CE/OE/WE and lane selects with a configurable number of wait states, and returns read bytes with a one-cycle acknowledge.

---
 rtl/sram_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port (CPU/PPU) byte arbiter for the shared 16-bit asynchronous board SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed PPU priority.
module sram_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        ppu_req,
  input  logic        ppu_we,
  input  logic [20:0] ppu_addr,
  input  logic [7:0]  ppu_wdata,
  output logic [7:0]  ppu_rdata,
  output logic        ppu_ack,
  output logic [19:0] sram_addr,
  inout  wire  [15:0] sram_data,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic        sram_we,
  output logic        sram_ub,
  output logic        sram_lb
);

  localparam int unsigned AW  = 21;
  localparam int unsigned DW  = 8;
  localparam int unsigned SAW = 20;
  localparam int unsigned SDW = 16;
  localparam int unsigned CW  = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            win_ppu, win_ppu_n;
  logic            lat_we, lat_we_n;
  logic [AW-1:0]   lat_addr, lat_addr_n;
  logic [DW-1:0]   lat_wdata, lat_wdata_n;
  logic [DW-1:0]   cpu_rdata_n, ppu_rdata_n;
  logic            cpu_ack_n, ppu_ack_n;
  logic [SAW-1:0]  sram_addr_n;
  logic            sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic            drive_en, drive_en_n;
  logic [SDW-1:0]  drive_data, drive_data_n;
  logic            grant, grant_ppu;
  logic [DW-1:0]   rd_byte;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic            last_ppu, last_ppu_n;
`endif

  assign sram_data = drive_en ? drive_data : {SDW{1'bz}};
  assign rd_byte   = lat_addr[0] ? sram_data[15:8] : sram_data[7:0];

  // Next-state, latch and registered-output computation
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    win_ppu_n    = win_ppu;
    lat_we_n     = lat_we;
    lat_addr_n   = lat_addr;
    lat_wdata_n  = lat_wdata;
    cpu_rdata_n  = cpu_rdata;
    ppu_rdata_n  = ppu_rdata;
    cpu_ack_n    = 1'b0;
    ppu_ack_n    = 1'b0;
    grant        = 1'b0;
    grant_ppu    = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_ppu_n   = last_ppu;
`endif

    case (state)
      IDLE: begin
        if (ppu_req || cpu_req) begin
          grant = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          grant_ppu = ppu_req && (!cpu_req || !last_ppu);
`else
          grant_ppu = ppu_req;
`endif
        end
      end
      ACCESS: begin
        if (cnt == CW'(WAIT_STATES)) begin
          state_n = DONE;
          if (win_ppu) begin
            ppu_ack_n = 1'b1;
            if (!lat_we) ppu_rdata_n = rd_byte;
          end else begin
            cpu_ack_n = 1'b1;
            if (!lat_we) cpu_rdata_n = rd_byte;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (win_ppu ? cpu_req : ppu_req) begin
          grant     = 1'b1;
          grant_ppu = !win_ppu;
        end
`else
        // A PPU still requesting keeps priority; it is re-granted through IDLE.
        if (win_ppu ? (cpu_req && !ppu_req) : ppu_req) begin
          grant     = 1'b1;
          grant_ppu = !win_ppu;
        end
`endif
      end
      default: state_n = IDLE;
    endcase

    if (grant) begin
      state_n     = ACCESS;
      cnt_n       = '0;
      win_ppu_n   = grant_ppu;
      lat_we_n    = grant_ppu ? ppu_we    : cpu_we;
      lat_addr_n  = grant_ppu ? ppu_addr  : cpu_addr;
      lat_wdata_n = grant_ppu ? ppu_wdata : cpu_wdata;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_ppu_n  = grant_ppu;
`endif
    end

    // SRAM pin values for the state being entered
    sram_addr_n  = sram_addr;
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_ub_n    = 1'b1;
    sram_lb_n    = 1'b1;
    drive_en_n   = 1'b0;
    drive_data_n = drive_data;
    case (state_n)
      ACCESS: begin
        sram_addr_n = lat_addr_n[AW-1:1];
        sram_ce_n   = 1'b0;
        sram_lb_n   = lat_addr_n[0];
        sram_ub_n   = !lat_addr_n[0];
        if (lat_we_n) begin
          sram_we_n    = 1'b0;
          drive_en_n   = 1'b1;
          drive_data_n = {lat_wdata_n, lat_wdata_n};
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      DONE: begin
        // Writes keep address, chip enable, lane and data for the hold time.
        if (lat_we_n) begin
          sram_ce_n  = 1'b0;
          sram_lb_n  = lat_addr_n[0];
          sram_ub_n  = !lat_addr_n[0];
          drive_en_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      win_ppu    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_rdata  <= '0;
      ppu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      ppu_ack    <= 1'b0;
      sram_addr  <= '0;
      sram_ce    <= 1'b1;
      sram_oe    <= 1'b1;
      sram_we    <= 1'b1;
      sram_ub    <= 1'b1;
      sram_lb    <= 1'b1;
      drive_en   <= 1'b0;
      drive_data <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_ppu   <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      win_ppu    <= win_ppu_n;
      lat_we     <= lat_we_n;
      lat_addr   <= lat_addr_n;
      lat_wdata  <= lat_wdata_n;
      cpu_rdata  <= cpu_rdata_n;
      ppu_rdata  <= ppu_rdata_n;
      cpu_ack    <= cpu_ack_n;
      ppu_ack    <= ppu_ack_n;
      sram_addr  <= sram_addr_n;
      sram_ce    <= sram_ce_n;
      sram_oe    <= sram_oe_n;
      sram_we    <= sram_we_n;
      sram_ub    <= sram_ub_n;
      sram_lb    <= sram_lb_n;
      drive_en   <= drive_en_n;
      drive_data <= drive_data_n;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_ppu   <= last_ppu_n;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural asynchronous SRAM model.
module tb_sram_arbiter;

  localparam int unsigned WS = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ppu_req, ppu_we;
  logic [20:0] cpu_addr, ppu_addr;
  logic [7:0]  cpu_wdata, ppu_wdata, cpu_rdata, ppu_rdata;
  logic        cpu_ack, ppu_ack;
  logic [19:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_ce, sram_oe, sram_we, sram_ub, sram_lb;

  logic [15:0] mem [0:1023];
  logic [15:0] bus_z;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        ppu;
    logic        we;
    logic [20:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic [19:0] exp_saddr;
    logic        exp_ub;
    logic        exp_lb;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs [8];

  sram_arbiter #(.WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
    .ppu_rdata(ppu_rdata), .ppu_ack(ppu_ack),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram_ub(sram_ub), .sram_lb(sram_lb)
  );

  always #5 clock = ~clock;

  // SRAM model: drives the whole word on reads, writes enabled lanes at each clock
  assign sram_data = (!sram_ce && !sram_oe && sram_we) ? mem[sram_addr[9:0]] : 16'hzzzz;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[8] = 16'hBEEF;
    forever begin
      @(posedge clock);
      if (!sram_ce && !sram_we) begin
        if (!sram_lb) mem[sram_addr[9:0]][7:0]  = sram_data[7:0];
        if (!sram_ub) mem[sram_addr[9:0]][15:8] = sram_data[15:8];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_txn(input vec_t v);
    int  n;
    logic got;
    if (v.ppu) begin
      ppu_req = 1'b1; ppu_we = v.we; ppu_addr = v.addr; ppu_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    step();
    chk("access_pins", 64'({sram_ce, sram_oe, sram_we, sram_ub, sram_lb, sram_addr}),
        64'({1'b0, v.we, !v.we, v.exp_ub, v.exp_lb, v.exp_saddr}));
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      step();
      n++;
      got = v.ppu ? ppu_ack : cpu_ack;
    end
    chk("ack_latency", 64'(n), 64'(WS + 1));
    if (v.we) chk("done_pins", 64'({sram_ce, sram_oe, sram_we}), 64'(3'b011));
    else      chk("rdata", 64'(v.ppu ? ppu_rdata : cpu_rdata), 64'(v.exp_rdata));
    cpu_req = 1'b0;
    ppu_req = 1'b0;
    step();
    if (v.we) chk("mem_word", 64'(mem[v.exp_saddr[9:0]]), 64'(v.exp_word));
    chk("ack_clear", 64'({cpu_ack, ppu_ack}), 64'(0));
  endtask

  initial begin
    int   n, tp, tc, np, nc, seen;
    logic [7:0] seq, exp_seq;
    vec_t r;

    bus_z = 'z;
    vecs[0] = '{1'b0, 1'b1, 21'h005A2, 8'h3C, 8'h00, 20'h002D1, 1'b1, 1'b0, 16'h003C};
    vecs[1] = '{1'b0, 1'b1, 21'h005A3, 8'h7E, 8'h00, 20'h002D1, 1'b0, 1'b1, 16'h7E3C};
    vecs[2] = '{1'b1, 1'b0, 21'h005A3, 8'h00, 8'h7E, 20'h002D1, 1'b0, 1'b1, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 21'h005A2, 8'h00, 8'h3C, 20'h002D1, 1'b1, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 21'h1FFFFF, 8'hA5, 8'h00, 20'hFFFFF, 1'b0, 1'b1, 16'hA500};
    vecs[5] = '{1'b0, 1'b0, 21'h1FFFFF, 8'h00, 8'hA5, 20'hFFFFF, 1'b0, 1'b1, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 21'h1FFFFE, 8'h00, 8'h00, 20'hFFFFF, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 1'b0, 21'h000011, 8'h00, 8'hBE, 20'h00008, 1'b0, 1'b1, 16'h0000};

    reset = 1'b0;
    ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_wdata = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h000010; cpu_wdata = '0;

    // Reset held with a pending CPU request
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ctrl", 64'({sram_ce, sram_oe, sram_we, sram_ub, sram_lb}), 64'(5'b11111));
    end
    chk("rst_addr", 64'(sram_addr), 64'(0));
    chk("rst_bus", 64'(sram_data), 64'(bus_z));
    chk("rst_ack", 64'({cpu_ack, ppu_ack}), 64'(0));
    chk("rst_rdata", 64'({cpu_rdata, ppu_rdata}), 64'(0));
    reset = 1'b1;
    r = '{1'b0, 1'b0, 21'h000010, 8'h00, 8'hEF, 20'h00008, 1'b1, 1'b0, 16'h0000};
    do_txn(r);

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Simultaneous requests: PPU first, CPU handed over directly from DONE
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 21'h005A3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h005A2;
    tp = -1; tc = -1; n = 0;
    while (n < 30 && (tp < 0 || tc < 0)) begin
      step();
      n++;
      if (ppu_ack) begin
        tp = n; ppu_req = 1'b0;
        chk("tie_ppu_rdata", 64'(ppu_rdata), 64'(8'h7E));
      end
      if (cpu_ack) begin
        tc = n; cpu_req = 1'b0;
        chk("tie_cpu_rdata", 64'(cpu_rdata), 64'(8'h3C));
      end
    end
    chk("tie_ppu_first", 64'(tp < tc && tp > 0), 64'(1));
    chk("tie_ack_gap", 64'(tc - tp), 64'(WS + 2));
    step();

    // Both ports requesting continuously
    ppu_req = 1'b1; cpu_req = 1'b1;
    np = 0; nc = 0; seen = 0; seq = '0; n = 0;
    while (n < 200 && seen < 8) begin
      step();
      n++;
      if (ppu_ack) begin seq[seen] = 1'b1; seen++; np++; end
      if (cpu_ack) begin seen++; nc++; end
    end
    ppu_req = 1'b0; cpu_req = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_seq = 8'h55;
    chk("cont_ppu_acks", 64'(np), 64'(4));
    chk("cont_cpu_acks", 64'(nc), 64'(4));
`else
    exp_seq = 8'hFF;
    chk("cont_ppu_acks", 64'(np), 64'(8));
    chk("cont_cpu_acks", 64'(nc), 64'(0));
`endif
    chk("cont_order", 64'(seq), 64'(exp_seq));
    step(); step(); step();

    // Async reset in the middle of a write access
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h000100; cpu_wdata = 8'h55;
    step();
    chk("mid_we_low", 64'(sram_we), 64'(0));
    #2 reset = 1'b0;
    #1;
    chk("async_ctrl", 64'({sram_ce, sram_oe, sram_we, sram_ub, sram_lb}), 64'(5'b11111));
    chk("async_bus", 64'(sram_data), 64'(bus_z));
    chk("async_rdata", 64'(cpu_rdata), 64'(0));
    cpu_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) reset = 1'b1;
      if (cpu_ack || ppu_ack) seen++;
    end
    chk("async_no_ack", 64'(seen), 64'(0));
    chk("async_no_write", 64'(mem[10'h080]), 64'(0));
    r = '{1'b0, 1'b0, 21'h005A2, 8'h00, 8'h3C, 20'h002D1, 1'b1, 1'b0, 16'h0000};
    do_txn(r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
